div_array_sched: RTL

DIV_ARRAY_SCHED -- requirements
Module: div_array_sched

---
 rtl/div_array_sched.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/div_array_sched.sv
// div_array_sched: two-requester round-robin front end for an external
// combinational 16/8 restoring array divider. Accepts one request at a time,
// waits SETTLE_CYCLES for the array to settle, captures the result and holds
// it on a valid/ready response channel. Divide-by-zero bypasses the array.
//
// Parameters:
//   SETTLE_CYCLES  cycles the array is given to settle (1..15)
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   reqk_valid/ready/n/d     request channel k (k = 0,1): dividend, divisor
//   div_n, div_d             operands driven into the divider array
//   div_q, div_r             quotient / remainder returned by the array
//   rsp_valid/ready          response handshake
//   rsp_id, rsp_q, rsp_r     requester index, quotient, remainder
//   rsp_dz, rsp_ovf          divide-by-zero, quotient overflow
// Configuration:
//   DIV_SCHED_OVF_CHECK_EN   when defined, flags quotient overflow at accept
//                            (n[15:8] >= d, d != 0); otherwise rsp_ovf is 0.

module div_array_sched #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [15:0] req0_n,
    input  logic [7:0]  req0_d,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [15:0] req1_n,
    input  logic [7:0]  req1_d,
    output logic [15:0] div_n,
    output logic [7:0]  div_d,
    input  logic [7:0]  div_q,
    input  logic [7:0]  div_r,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [7:0]  rsp_q,
    output logic [7:0]  rsp_r,
    output logic        rsp_dz,
    output logic        rsp_ovf
);

    localparam int unsigned NW = 16;
    localparam int unsigned DW = 8;
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          last_grant, last_grant_nx;
    logic [NW-1:0] n_nx;
    logic [DW-1:0] d_nx;
    logic          id_nx;
    logic [DW-1:0] q_nx, r_nx;
    logic          dz_nx;

    logic          gnt0, gnt1;
    logic          accept;
    logic          acc_id;
    logic [NW-1:0] acc_n;
    logic [DW-1:0] acc_d;

    // Round-robin grant: a lone requester wins; on contention the one not
    // granted last wins.
    assign gnt0   = req0_valid & (~req1_valid | last_grant);
    assign gnt1   = req1_valid & (~req0_valid | ~last_grant);
    assign accept = (state == IDLE) & (gnt0 | gnt1);
    assign acc_id = gnt1;
    assign acc_n  = gnt1 ? req1_n : req0_n;
    assign acc_d  = gnt1 ? req1_d : req0_d;

    assign req0_ready = (state == IDLE) & gnt0;
    assign req1_ready = (state == IDLE) & gnt1;
    assign rsp_valid  = (state == DONE);

    // Next-state and datapath load logic.
    always_comb begin
        state_nx      = state;
        cnt_nx        = cnt;
        last_grant_nx = last_grant;
        n_nx          = div_n;
        d_nx          = div_d;
        id_nx         = rsp_id;
        q_nx          = rsp_q;
        r_nx          = rsp_r;
        dz_nx         = rsp_dz;
        case (state)
            IDLE: begin
                if (accept) begin
                    last_grant_nx = acc_id;
                    n_nx          = acc_n;
                    d_nx          = acc_d;
                    id_nx         = acc_id;
                    if (acc_d == '0) begin
                        // Array output is meaningless for d == 0; answer directly.
                        state_nx = DONE;
                        cnt_nx   = '0;
                        q_nx     = 8'hFF;
                        r_nx     = acc_n[DW-1:0];
                        dz_nx    = 1'b1;
                    end else begin
                        state_nx = SETTLE;
                        cnt_nx   = CW'(SETTLE_CYCLES - 1);
                        dz_nx    = 1'b0;
                    end
                end
            end
            SETTLE: begin
                if (cnt == '0) begin
                    state_nx = DONE;
                    q_nx     = div_q;
                    r_nx     = div_r;
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            last_grant <= 1'b1;
            div_n      <= '0;
            div_d      <= '0;
            rsp_id     <= 1'b0;
            rsp_q      <= '0;
            rsp_r      <= '0;
            rsp_dz     <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            last_grant <= last_grant_nx;
            div_n      <= n_nx;
            div_d      <= d_nx;
            rsp_id     <= id_nx;
            rsp_q      <= q_nx;
            rsp_r      <= r_nx;
            rsp_dz     <= dz_nx;
        end
    end

`ifdef DIV_SCHED_OVF_CHECK_EN
    logic ovf_flag, ovf_nx;

    // Quotient cannot fit in 8 bits when the dividend's high byte reaches d.
    always_comb begin
        ovf_nx = ovf_flag;
        if (accept) begin
            ovf_nx = (acc_n[NW-1:DW] >= acc_d) && (acc_d != '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_flag <= 1'b0;
        end else begin
            ovf_flag <= ovf_nx;
        end
    end

    assign rsp_ovf = ovf_flag;
`else
    assign rsp_ovf = 1'b0;
`endif

endmodule
